// File: rtl/nbit_mosi_spi_buffer_if.sv
// -----------------------------------------------------------------------------
// nbit_mosi_spi_buffer_if
// Bus between the display controller FSM and the buffered SPI MOSI
// transmitter. Clock and reset are not part of the bus.
//
// Signals
//   i_START          start request, level-sampled while the transmitter idles
//   i_DATA           N words of WIDTH bits, word k = i_DATA[k*WIDTH +: WIDTH]
//   i_DC             D/C flag per word, bit k belongs to word k
//   i_N_transmit     number of words to send (clamped to N)
//   o_MOSI           serial data, MSB first
//   o_CS             chip select, active-low
//   o_DC             D/C flag of the word currently shifting
//   o_MOSI_FINAL_TX  one-cycle pulse after the last bit of a frame
//
// Modports
//   master  display controller side (drives the request)
//   slave   transmitter side (drives the OLED pins)
// -----------------------------------------------------------------------------
interface nbit_mosi_spi_buffer_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 8
);
   logic                 i_START;
   logic [N*WIDTH-1:0]   i_DATA;
   logic [N-1:0]         i_DC;
   logic [4:0]           i_N_transmit;
   logic                 o_MOSI;
   logic                 o_CS;
   logic                 o_DC;
   logic                 o_MOSI_FINAL_TX;

   modport master (
      output i_START, i_DATA, i_DC, i_N_transmit,
      input  o_MOSI, o_CS, o_DC, o_MOSI_FINAL_TX
   );

   modport slave (
      input  i_START, i_DATA, i_DC, i_N_transmit,
      output o_MOSI, o_CS, o_DC, o_MOSI_FINAL_TX
   );
endinterface

// File: rtl/nbit_mosi_spi_buffer.sv
// -----------------------------------------------------------------------------
// nbit_mosi_spi_buffer
// Buffered SPI MOSI transmitter for the SSD1331 OLED path. On a start request
// it latches up to N command/data words with their D/C flags and shifts them
// out back-to-back, MSB first, with chip select held low for the whole frame.
// The display SCLK pin is ~i_SCK (driven outside), so the panel samples
// mid-bit.
//
// Parameters
//   WIDTH  bits per word
//   N      buffer depth in words (1..31)
//
// Ports
//   i_SCK  clock, all state updates on the rising edge
//   i_RST  asynchronous active-high reset; aborts a frame without a final pulse
//   bus    nbit_mosi_spi_buffer_if.slave (request in, OLED pins out)
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module nbit_mosi_spi_buffer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 8
) (
   input  logic                   i_SCK,
   input  logic                   i_RST,
   nbit_mosi_spi_buffer_if.slave  bus
);

   localparam int unsigned     BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [4:0]      N_MAX   = 5'(N);
   localparam logic [BW-1:0]   BIT_TOP = BW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t               state_q, state_d;

   // Words still to be sent after the current one; the next word always sits
   // in the low WIDTH bits, so no variable indexing of the buffer is needed.
   logic [N*WIDTH-1:0]   buf_q, buf_d;
   logic [N-1:0]         flag_q, flag_d;
   // Remaining bits of the current word, next bit to send in the MSB.
   logic [WIDTH-1:0]     cur_q, cur_d;

   logic [BW-1:0]        bit_q, bit_d;     // index of the bit currently on o_MOSI
   logic [4:0]           word_q, word_d;   // index of the word currently shifting
   logic [4:0]           cnt_q, cnt_d;     // words in this frame
   logic [4:0]           cnt_in;

   logic                 mosi_q, mosi_d;
   logic                 cs_q, cs_d;
   logic                 dc_q, dc_d;
   logic                 final_q, final_d;

   logic                 start_ok;
   logic                 bit_last;
   logic                 word_last;

   assign cnt_in    = (bus.i_N_transmit > N_MAX) ? N_MAX : bus.i_N_transmit;
   assign start_ok  = bus.i_START && (cnt_in != '0);
   assign bit_last  = (bit_q == '0);
   assign word_last = (word_q == (cnt_q - 5'd1));

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge i_SCK or posedge i_RST) begin
      if (i_RST) begin
         state_q <= IDLE;
         buf_q   <= '0;
         flag_q  <= '0;
         cur_q   <= '0;
         bit_q   <= '0;
         word_q  <= '0;
         cnt_q   <= '0;
         mosi_q  <= 1'b0;
         cs_q    <= 1'b1;
         dc_q    <= 1'b0;
         final_q <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         flag_q  <= flag_d;
         cur_q   <= cur_d;
         bit_q   <= bit_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
         mosi_q  <= mosi_d;
         cs_q    <= cs_d;
         dc_q    <= dc_d;
         final_q <= final_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_d = SHIFT;
         SHIFT:   if (bit_last && word_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Next output / datapath values. The first bit of word 0 is presented at
   // the start edge itself, so each SHIFT edge presents the following bit and
   // the edge after the last bit closes the frame.
   // ------------------------------------------------------------------------
   always_comb begin
      buf_d   = buf_q;
      flag_d  = flag_q;
      cur_d   = cur_q;
      bit_d   = bit_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      mosi_d  = mosi_q;
      cs_d    = cs_q;
      dc_d    = dc_q;
      final_d = 1'b0;

      case (state_q)
         IDLE: begin
            cs_d   = 1'b1;
            mosi_d = 1'b0;
            dc_d   = 1'b0;
            if (bus.i_START) begin
               cnt_d = cnt_in;
            end
            if (start_ok) begin
               cs_d   = 1'b0;
               mosi_d = bus.i_DATA[WIDTH-1];
               dc_d   = bus.i_DC[0];
               cur_d  = bus.i_DATA[WIDTH-1:0] << 1;
               buf_d  = bus.i_DATA >> WIDTH;
               flag_d = bus.i_DC >> 1;
               bit_d  = BIT_TOP;
               word_d = '0;
            end
         end

         SHIFT: begin
            if (!bit_last) begin
               mosi_d = cur_q[WIDTH-1];
               cur_d  = cur_q << 1;
               bit_d  = bit_q - BW'(1);
            end else if (!word_last) begin
               mosi_d = buf_q[WIDTH-1];
               cur_d  = buf_q[WIDTH-1:0] << 1;
               buf_d  = buf_q >> WIDTH;
               dc_d   = flag_q[0];
               flag_d = flag_q >> 1;
               bit_d  = BIT_TOP;
               word_d = word_q + 5'd1;
            end else begin
               cs_d    = 1'b1;
               mosi_d  = 1'b0;
               dc_d    = 1'b0;
               final_d = 1'b1;
            end
         end

         default: begin
            cs_d   = 1'b1;
            mosi_d = 1'b0;
            dc_d   = 1'b0;
         end
      endcase
   end

   assign bus.o_MOSI          = mosi_q;
   assign bus.o_CS            = cs_q;
   assign bus.o_DC            = dc_q;
   assign bus.o_MOSI_FINAL_TX = final_q;

endmodule

// File: tb/tb_nbit_mosi_spi_buffer.sv
// -----------------------------------------------------------------------------
// tb_nbit_mosi_spi_buffer
// Directed bench for nbit_mosi_spi_buffer (WIDTH=8, N=8). Outputs are sampled
// on the falling edge of i_SCK, inputs are changed on the falling edge.
// -----------------------------------------------------------------------------
module tb_nbit_mosi_spi_buffer;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned N     = 8;

   logic clk;
   logic rst;

   int unsigned n_checks;
   int unsigned n_errors;

   nbit_mosi_spi_buffer_if #(.WIDTH(WIDTH), .N(N)) bus_if ();

   nbit_mosi_spi_buffer #(.WIDTH(WIDTH), .N(N)) dut (
      .i_SCK (clk),
      .i_RST (rst),
      .bus   (bus_if.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge: drive the request, let one rising edge see it.
   task automatic start_frame(input logic [63:0] data, input logic [7:0] dcv,
                              input logic [4:0] n, input bit hold);
      bus_if.i_DATA       = data;
      bus_if.i_DC         = dcv;
      bus_if.i_N_transmit = n;
      bus_if.i_START      = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) bus_if.i_START = 1'b0;
   endtask

   // Follows a frame started at the preceding rising edge: nw words, then the
   // cycle carrying the final pulse. Returns at that falling edge.
   task automatic expect_frame(input string tag, input logic [63:0] data,
                               input logic [7:0] dcv, input int unsigned nw);
      logic [7:0]  w;
      logic [7:0]  d;
      int unsigned cs_hi;
      int unsigned fin;
      cs_hi = 0;
      fin   = 0;
      for (int unsigned k = 0; k < nw; k++) begin
         w = '0;
         d = '0;
         for (int unsigned b = 0; b < WIDTH; b++) begin
            @(negedge clk);
            w = {w[6:0], bus_if.o_MOSI};
            d = {d[6:0], bus_if.o_DC};
            if (bus_if.o_CS !== 1'b0) cs_hi++;
            if (bus_if.o_MOSI_FINAL_TX !== 1'b0) fin++;
         end
         check($sformatf("%s word%0d", tag, k), {56'd0, w}, {56'd0, data[k*8 +: 8]});
         check($sformatf("%s dc%0d", tag, k), {56'd0, d}, {56'd0, {8{dcv[k]}}});
      end
      check({tag, " cs_low_cycles"}, 64'(cs_hi), 64'd0);
      check({tag, " no_early_final"}, 64'(fin), 64'd0);
      @(negedge clk);
      check({tag, " end {cs,final,mosi,dc}"},
            {60'd0, bus_if.o_CS, bus_if.o_MOSI_FINAL_TX, bus_if.o_MOSI, bus_if.o_DC},
            64'b1100);
   endtask

   // CS must stay high and no pulse may appear for the given number of cycles.
   task automatic idle_check(input string tag, input int unsigned cycles);
      int unsigned bad;
      bad = 0;
      for (int unsigned i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus_if.o_CS !== 1'b1 || bus_if.o_MOSI_FINAL_TX !== 1'b0 ||
             bus_if.o_MOSI !== 1'b0 || bus_if.o_DC !== 1'b0) bad++;
      end
      check({tag, " idle_bad_cycles"}, 64'(bad), 64'd0);
   endtask

   initial begin
      n_checks            = 0;
      n_errors            = 0;
      rst                 = 1'b1;
      bus_if.i_START      = 1'b0;
      bus_if.i_DATA       = '0;
      bus_if.i_DC         = '0;
      bus_if.i_N_transmit = '0;

      #1;
      check("reset {cs,final,mosi,dc}",
            {60'd0, bus_if.o_CS, bus_if.o_MOSI_FINAL_TX, bus_if.o_MOSI, bus_if.o_DC},
            64'b1000);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle_check("post_reset", 2);

      // Basic frame: 01 02 04 08, DC 1,0,1,0
      start_frame(64'h0000_0000_0804_0201, 8'b0000_0101, 5'd4, 1'b0);
      expect_frame("basic", 64'h0000_0000_0804_0201, 8'b0000_0101, 4);
      @(negedge clk);
      check("basic final_one_cycle", {63'd0, bus_if.o_MOSI_FINAL_TX}, 64'd0);

      // Zero-length request is ignored
      start_frame(64'h1122_3344_5566_7788, 8'hFF, 5'd0, 1'b0);
      idle_check("zero", 4);

      // Count above N clamps to N
      start_frame(64'h0123_4567_89AB_CDEF, 8'b1001_0110, 5'd12, 1'b0);
      expect_frame("clamp", 64'h0123_4567_89AB_CDEF, 8'b1001_0110, 8);
      idle_check("clamp_after", 3);

      // Held start: two 2-word frames separated by the final-pulse cycle
      start_frame(64'h0000_0000_0000_C33C, 8'b0000_0010, 5'd2, 1'b1);
      expect_frame("held1", 64'h0000_0000_0000_C33C, 8'b0000_0010, 2);
      expect_frame("held2", 64'h0000_0000_0000_C33C, 8'b0000_0010, 2);
      bus_if.i_START = 1'b0;
      idle_check("held_after", 3);

      // Start pulse and data change while busy are ignored
      start_frame(64'h0000_0000_55AA_F00F, 8'b0000_1100, 5'd4, 1'b0);
      fork
         expect_frame("busy", 64'h0000_0000_55AA_F00F, 8'b0000_1100, 4);
         begin
            repeat (10) @(negedge clk);
            bus_if.i_START      = 1'b1;
            bus_if.i_DATA       = 64'hFFFF_FFFF_FFFF_FFFF;
            bus_if.i_DC         = 8'h00;
            bus_if.i_N_transmit = 5'd8;
            @(negedge clk);
            bus_if.i_START      = 1'b0;
         end
      join
      idle_check("busy_after", 4);

      // Reset at bit 5 of word 1 (cycle 11)
      start_frame(64'h0000_0000_0000_FF00, 8'b0000_0011, 5'd4, 1'b0);
      repeat (11) @(negedge clk);
      check("pre_reset {cs,mosi,dc}",
            {61'd0, bus_if.o_CS, bus_if.o_MOSI, bus_if.o_DC}, 64'b011);
      rst = 1'b1;
      #1;
      check("mid_reset {cs,final,mosi,dc}",
            {60'd0, bus_if.o_CS, bus_if.o_MOSI_FINAL_TX, bus_if.o_MOSI, bus_if.o_DC},
            64'b1000);
      idle_check("in_reset", 2);
      rst = 1'b0;
      idle_check("after_reset", 3);
      start_frame(64'h0000_0000_0000_3C81, 8'b0000_0001, 5'd2, 1'b0);
      expect_frame("restart", 64'h0000_0000_0000_3C81, 8'b0000_0001, 2);

      // Single word
      @(negedge clk);
      start_frame(64'h0000_0000_0000_00A5, 8'b0000_0001, 5'd1, 1'b0);
      expect_frame("single", 64'h0000_0000_0000_00A5, 8'b0000_0001, 1);
      @(negedge clk);
      check("single after {cs,final}",
            {62'd0, bus_if.o_CS, bus_if.o_MOSI_FINAL_TX}, 64'b10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
